data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder_pkg.sv | 23 ++
 rtl/data_sram_responder_array.sv | 30 +++
 rtl/data_sram_responder.sv | 84 ++++++++
 tb/tb_data_sram_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data-SRAM responder.
package data_sram_responder_pkg;

  localparam int unsigned DSRAM_WORD_W = 32;
  localparam int unsigned DSRAM_STRB_W = 4;

  localparam logic [DSRAM_WORD_W-1:0] DSRAM_OOR_RDATA = 32'h0;

  // Strobed bytes come from wdata, the rest keep the old word.
  function automatic logic [DSRAM_WORD_W-1:0] dsram_byte_merge(
    input logic [DSRAM_WORD_W-1:0] old_word,
    input logic [DSRAM_WORD_W-1:0] wdata,
    input logic [DSRAM_STRB_W-1:0] strb
  );
    logic [DSRAM_WORD_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < DSRAM_STRB_W; i++) begin
      if (strb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_responder_array.sv
// Bare word storage: strobed synchronous write, combinational read of mem[idx].
module dsram_array
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 65536,
  parameter int unsigned IDX_W = 16
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DSRAM_STRB_W-1:0] strb,
  input  logic [DSRAM_WORD_W-1:0] wdata,
  output logic [DSRAM_WORD_W-1:0] rdata
);

  logic [DSRAM_WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < DSRAM_STRB_W; i++) begin
        if (strb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata = mem[idx];
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: one-cycle-latency word memory with range check and debug counters.
// Define DSRAM_WR_FORWARD_EN for write-first read data on write cycles (default read-first).
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 65536,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_sram_en,
  input  logic [DSRAM_STRB_W-1:0] data_sram_we,
  input  logic [ADDR_W-1:0]       data_sram_addr,
  input  logic [DSRAM_WORD_W-1:0] data_sram_wdata,
  output logic [DSRAM_WORD_W-1:0] data_sram_rdata,
  output logic                    oor_err,
  output logic [31:0]             rd_cnt,
  output logic [31:0]             wr_cnt
);

  logic [IDX_W-1:0]        idx;
  logic [ADDR_W-1:0]       addr_hi;
  logic                    in_range;
  logic                    is_write;
  logic                    wr_en;
  logic [DSRAM_WORD_W-1:0] mem_rdata;
  logic [DSRAM_WORD_W-1:0] rdata_next;
  logic                    unused_addr_lo;

  assign unused_addr_lo = ^data_sram_addr[1:0];

  always_comb begin
    idx      = data_sram_addr[IDX_W+1:2];
    addr_hi  = data_sram_addr >> (IDX_W + 2);
    in_range = (addr_hi == '0);
    is_write = (data_sram_we != '0);
    // Memory write is independent of reset: contents survive a reset cycle.
    wr_en    = data_sram_en && is_write && in_range;
  end

  dsram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .wr_en (wr_en),
    .idx   (idx),
    .strb  (data_sram_we),
    .wdata (data_sram_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    rdata_next = mem_rdata;
    if (!in_range) begin
      rdata_next = DSRAM_OOR_RDATA;
    end
`ifdef DSRAM_WR_FORWARD_EN
    else if (is_write) begin
      rdata_next = dsram_byte_merge(mem_rdata, data_sram_wdata, data_sram_we);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sram_rdata <= '0;
      oor_err         <= 1'b0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
    end else if (data_sram_en) begin
      data_sram_rdata <= rdata_next;
      if (!in_range) begin
        oor_err <= 1'b1;
      end else if (is_write) begin
        wr_cnt <= wr_cnt + 32'd1;
      end else begin
        rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        oor_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  data_sram_responder #(
    .DEPTH  (65536),
    .ADDR_W (32),
    .IDX_W  (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .oor_err         (oor_err),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    checks++; if (oor_err !== 1'b0) begin errors++; $display("FAIL reset_oor got=%b exp=0", oor_err); end
    checks++; if (rd_cnt !== 32'd0) begin errors++; $display("FAIL reset_rd_cnt got=%0d exp=0", rd_cnt); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL reset_wr_cnt got=%0d exp=0", wr_cnt); end
  endtask

  task automatic test_full_write_read();
    drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF); tick();
    drive(1'b1, 4'h0, 32'h10, 32'h0);        tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL full_rd got=%h exp=%h", rdata, 32'hDEADBEEF); end
    checks++; if (wr_cnt !== 32'd1) begin errors++; $display("FAIL full_wr_cnt got=%0d exp=1", wr_cnt); end
    checks++; if (rd_cnt !== 32'd1) begin errors++; $display("FAIL full_rd_cnt got=%0d exp=1", rd_cnt); end
  endtask

  task automatic test_byte_strobes();
    drive(1'b1, 4'hF, 32'h20, 32'h11223344);    tick();
    drive(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD); tick();
    drive(1'b1, 4'h0, 32'h20, 32'h0);           tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (rdata !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_rd got=%h exp=%h", rdata, 32'h11BB33DD); end
    checks++; if (wr_cnt !== 32'd3) begin errors++; $display("FAIL strobe_wr_cnt got=%0d exp=3", wr_cnt); end
    checks++; if (rd_cnt !== 32'd2) begin errors++; $display("FAIL strobe_rd_cnt got=%0d exp=2", rd_cnt); end
  endtask

  task automatic test_write_forward();
    logic [31:0] exp_wr;
`ifdef DSRAM_WR_FORWARD_EN
    exp_wr = 32'hFFFFFFFF;
`else
    exp_wr = 32'h00000000;
`endif
    drive(1'b1, 4'hF, 32'h30, 32'h0);        tick();
    drive(1'b1, 4'hF, 32'h30, 32'hFFFFFFFF); tick();
    drive(1'b1, 4'h0, 32'h30, 32'h0);
    checks++; if (rdata !== exp_wr) begin errors++; $display("FAIL wr_cycle_rdata got=%h exp=%h", rdata, exp_wr); end
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL wr_readback got=%h exp=%h", rdata, 32'hFFFFFFFF); end
    checks++; if (wr_cnt !== 32'd5) begin errors++; $display("FAIL fwd_wr_cnt got=%0d exp=5", wr_cnt); end
    checks++; if (rd_cnt !== 32'd3) begin errors++; $display("FAIL fwd_rd_cnt got=%0d exp=3", rd_cnt); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'hF, 32'h0, 32'h01010101); tick();
    drive(1'b1, 4'hF, 32'h4, 32'h02020202); tick();
    drive(1'b1, 4'hF, 32'h8, 32'h03030303); tick();
    drive(1'b1, 4'h0, 32'h0, 32'h0); tick();
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    checks++; if (rdata !== 32'h01010101) begin errors++; $display("FAIL b2b_0 got=%h exp=%h", rdata, 32'h01010101); end
    tick();
    drive(1'b1, 4'h0, 32'h8, 32'h0);
    checks++; if (rdata !== 32'h02020202) begin errors++; $display("FAIL b2b_4 got=%h exp=%h", rdata, 32'h02020202); end
    tick();
    // Idle with a stray write strobe; it must be ignored.
    drive(1'b0, 4'hF, 32'h0, 32'hCAFEF00D);
    checks++; if (rdata !== 32'h03030303) begin errors++; $display("FAIL b2b_8 got=%h exp=%h", rdata, 32'h03030303); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rdata !== 32'h03030303) begin errors++; $display("FAIL idle_hold_%0d got=%h exp=%h", i, rdata, 32'h03030303); end
    end
    checks++; if (wr_cnt !== 32'd8) begin errors++; $display("FAIL idle_wr_cnt got=%0d exp=8", wr_cnt); end
    checks++; if (rd_cnt !== 32'd6) begin errors++; $display("FAIL idle_rd_cnt got=%0d exp=6", rd_cnt); end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_out_of_range();
    checks++; if (oor_err !== 1'b0) begin errors++; $display("FAIL oor_pre got=%b exp=0", oor_err); end
    drive(1'b1, 4'hF, 32'h0004_0000, 32'h55555555); tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_set got=%b exp=1", oor_err); end
    checks++; if (wr_cnt !== 32'd8) begin errors++; $display("FAIL oor_wr_cnt got=%0d exp=8", wr_cnt); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL oor_wr_rdata got=%h exp=0", rdata); end
    tick();
    drive(1'b1, 4'h0, 32'h0, 32'h0); tick();
    checks++; if (rdata !== 32'h01010101) begin errors++; $display("FAIL oor_mem_kept got=%h exp=%h", rdata, 32'h01010101); end
    drive(1'b1, 4'h0, 32'h8004_0008, 32'h0); tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL oor_rd_rdata got=%h exp=0", rdata); end
    checks++; if (rd_cnt !== 32'd7) begin errors++; $display("FAIL oor_rd_cnt got=%0d exp=7", rd_cnt); end
    tick();
    tick();
    checks++; if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%b exp=1", oor_err); end
  endtask

  task automatic test_reset_midstream();
    reset = 1'b1;
    drive(1'b1, 4'hF, 32'h40, 32'h12345678); tick();
    reset = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata got=%h exp=0", rdata); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_wr_cnt got=%0d exp=0", wr_cnt); end
    checks++; if (rd_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_rd_cnt got=%0d exp=0", rd_cnt); end
    checks++; if (oor_err !== 1'b0) begin errors++; $display("FAIL rst_mid_oor got=%b exp=0", oor_err); end
    drive(1'b1, 4'h0, 32'h40, 32'h0); tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL rst_mid_mem got=%h exp=%h", rdata, 32'h12345678); end
    checks++; if (rd_cnt !== 32'd1) begin errors++; $display("FAIL rst_mid_rd_cnt2 got=%0d exp=1", rd_cnt); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_wr_cnt2 got=%0d exp=0", wr_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    test_reset();
    test_full_write_read();
    test_byte_strobes();
    test_write_forward();
    test_back_to_back();
    test_out_of_range();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
